// File: rtl/univ_shift_seq.sv
// Universal shift register: parallel load, logical/rotate/arithmetic shifts of STEP bits,
// with a counted-shift sequencer (start/busy/done) that runs N shifts on its own.
module univ_shift_seq #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [STEP-1:0]  sin,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] out,
   output logic [STEP-1:0]  sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [2:0] OP_LSL = 3'b001;
   localparam logic [2:0] OP_LSR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
   localparam logic [2:0] OP_ASR = 3'b101;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [2:0]         op_lat_q, op_lat_d;
   logic               done_q, done_d;
   logic [2:0]         eff_op;

   function automatic logic [WIDTH-1:0] shift_fn(input logic [2:0]       f_op,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic [STEP-1:0]  s_in);
      case (f_op)
         OP_LSL:  return {v[WIDTH-STEP-1:0], s_in};
         OP_LSR:  return {s_in, v[WIDTH-1:STEP]};
         OP_ROL:  return {v[WIDTH-STEP-1:0], v[WIDTH-1 -: STEP]};
         OP_ROR:  return {v[STEP-1:0], v[WIDTH-1:STEP]};
         OP_ASR:  return {{STEP{v[WIDTH-1]}}, v[WIDTH-1:STEP]};
         default: return v;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         out_q    <= '0;
         rem_q    <= '0;
         op_lat_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         rem_q    <= rem_d;
         op_lat_q <= op_lat_d;
         done_q   <= done_d;
      end
   end

   // Load wins over the sequencer; a running sequence ignores en, start, op and count.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      rem_d    = rem_q;
      op_lat_d = op_lat_q;
      done_d   = 1'b0;
      if (load) begin
         out_d   = load_data;
         state_d = IDLE;
         rem_d   = '0;
      end else if (state_q == RUN) begin
         out_d = shift_fn(op_lat_q, out_q, sin);
         rem_d = rem_q - CNT_W'(1);
         if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (start) begin
         if (count != '0) begin
            state_d  = RUN;
            rem_d    = count;
            op_lat_d = op;
         end else begin
            done_d = 1'b1;
         end
      end else if (en) begin
         out_d = shift_fn(op, out_q, sin);
      end
   end

   always_comb begin
      busy   = (state_q == RUN);
      eff_op = (state_q == RUN) ? op_lat_q : op;
      if (eff_op == OP_LSL || eff_op == OP_ROL)
         sout = out_q[WIDTH-1 -: STEP];
      else
         sout = out_q[STEP-1:0];
   end

   assign out  = out_q;
   assign done = done_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq: directed vector table, STEP=2 sequence, and random run vs. a reference model.
module tb_univ_shift_seq;

   logic       clk;
   logic       rst, en, load, sin, start;
   logic [2:0] op;
   logic [7:0] load_data;
   logic [3:0] count;
   logic [7:0] out;
   logic       sout, busy, done;

   logic       r2_rst, r2_en, r2_load, r2_start;
   logic [2:0] r2_op;
   logic [7:0] r2_load_data;
   logic [1:0] r2_sin;
   logic [3:0] r2_count;
   logic [7:0] r2_out;
   logic [1:0] r2_sout;
   logic       r2_busy, r2_done;

   int n_total = 0;
   int n_pass  = 0;

   univ_shift_seq #(.WIDTH(8), .STEP(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .op(op), .load(load), .load_data(load_data),
      .sin(sin), .start(start), .count(count), .out(out), .sout(sout),
      .busy(busy), .done(done)
   );

   univ_shift_seq #(.WIDTH(8), .STEP(2), .CNT_W(4)) dut2 (
      .clk(clk), .rst(r2_rst), .en(r2_en), .op(r2_op), .load(r2_load),
      .load_data(r2_load_data), .sin(r2_sin), .start(r2_start), .count(r2_count),
      .out(r2_out), .sout(r2_sout), .busy(r2_busy), .done(r2_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en;
      logic [2:0] op;
      logic       load;
      logic [7:0] ld;
      logic       sin, start;
      logic [3:0] cnt;
      logic [7:0] e_out;
      logic       e_busy, e_done, e_sout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic e, logic [2:0] o, logic l, logic [7:0] d,
                               logic s, logic st, logic [3:0] c,
                               logic [7:0] eo, logic eb, logic ed, logic es);
      vec_t v;
      v.rst = r; v.en = e; v.op = o; v.load = l; v.ld = d; v.sin = s; v.start = st;
      v.cnt = c; v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_sout = es;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference shift on an integer value of width w, moving s bits.
   function automatic int ref_shift(int f_op, int v, int fill, int w, int s);
      int mask;
      mask = (1 << w) - 1;
      case (f_op)
         1: return ((v << s) | fill) & mask;
         2: return (v >> s) | (fill << (w - s));
         3: return ((v << s) | (v >> (w - s))) & mask;
         4: return ((v >> s) | (v << (w - s))) & mask;
         5: return (v >> (w - 1)) != 0 ? ((v >> s) | (mask & ~(mask >> s))) : (v >> s);
         default: return v;
      endcase
   endfunction

   function automatic int ref_sout(int f_op, int v, int w, int s);
      if (f_op == 1 || f_op == 3) return v >> (w - s);
      return v & ((1 << s) - 1);
   endfunction

   int m_out, m_rem, m_lop;
   bit m_busy, m_done;

   initial begin
      rst = 0; en = 0; op = 0; load = 0; load_data = 0; sin = 0; start = 0; count = 0;
      r2_rst = 1; r2_en = 0; r2_op = 0; r2_load = 0; r2_load_data = 0; r2_sin = 0;
      r2_start = 0; r2_count = 0;

      vecs.push_back(mk(1,0,3'd0,0,8'h00,0,0,4'd0, 8'h00,0,0,0));
      vecs.push_back(mk(0,0,3'd0,1,8'hB4,0,0,4'd0, 8'hB4,0,0,0));
      vecs.push_back(mk(0,1,3'd3,0,8'h00,0,0,4'd0, 8'h69,0,0,0));
      vecs.push_back(mk(0,1,3'd3,0,8'h00,0,0,4'd0, 8'hD2,0,0,1));
      vecs.push_back(mk(0,1,3'd3,0,8'h00,0,0,4'd0, 8'hA5,0,0,1));
      vecs.push_back(mk(0,0,3'd0,1,8'h81,0,0,4'd0, 8'h81,0,0,1));
      vecs.push_back(mk(0,0,3'd5,0,8'h00,0,1,4'd3, 8'h81,1,0,1));
      vecs.push_back(mk(0,1,3'd0,0,8'h00,0,0,4'd0, 8'hC0,1,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'hE0,1,0,0));
      vecs.push_back(mk(0,1,3'd0,0,8'h00,0,0,4'd0, 8'hF0,0,1,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'hF0,0,0,0));
      vecs.push_back(mk(0,0,3'd0,1,8'h00,0,0,4'd0, 8'h00,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h01,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h03,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h07,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h0F,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h1F,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h3F,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'h7F,0,0,0));
      vecs.push_back(mk(0,1,3'd1,0,8'h00,1,0,4'd0, 8'hFF,0,0,1));
      vecs.push_back(mk(0,0,3'd2,0,8'h00,0,1,4'd5, 8'hFF,1,0,1));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'h7F,1,0,1));
      vecs.push_back(mk(0,0,3'd0,1,8'h3C,0,0,4'd0, 8'h3C,0,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'h3C,0,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,1,4'd0, 8'h3C,0,1,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'h3C,0,0,0));
      vecs.push_back(mk(0,0,3'd3,0,8'h00,0,1,4'd2, 8'h3C,1,0,0));
      vecs.push_back(mk(0,0,3'd1,0,8'h00,0,1,4'd7, 8'h78,1,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'hF0,0,1,0));
      vecs.push_back(mk(0,0,3'd2,0,8'h00,1,1,4'd1, 8'hF0,1,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,1,0,4'd0, 8'hF8,0,1,0));
      vecs.push_back(mk(0,0,3'd3,0,8'h00,0,1,4'd4, 8'hF8,1,0,1));
      vecs.push_back(mk(1,0,3'd0,0,8'h00,0,0,4'd0, 8'h00,0,0,0));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'h00,0,0,0));
      vecs.push_back(mk(0,0,3'd0,1,8'hA5,0,1,4'd3, 8'hA5,0,0,1));
      vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0,4'd0, 8'hA5,0,0,1));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; en = vecs[i].en; op = vecs[i].op; load = vecs[i].load;
         load_data = vecs[i].ld; sin = vecs[i].sin; start = vecs[i].start;
         count = vecs[i].cnt;
         step();
         if (i == 0) r2_rst = 0;
         check($sformatf("vec%0d.out", i), int'(out), int'(vecs[i].e_out));
         check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
         check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].e_done));
         check($sformatf("vec%0d.sout", i), int'(sout), int'(vecs[i].e_sout));
      end

      // STEP=2 instance: rotate right, then logical right with a 2-bit fill
      r2_load = 1; r2_load_data = 8'hC3;
      step();
      check("s2.load", int'(r2_out), 'hC3);
      r2_load = 0; r2_op = 3'b100; r2_en = 1;
      step();
      check("s2.ror.out", int'(r2_out), 'hF0);
      check("s2.ror.sout", int'(r2_sout), 0);
      r2_op = 3'b010; r2_sin = 2'b10;
      step();
      check("s2.lsr.out", int'(r2_out), 'hBC);
      r2_op = 3'b101;
      step();
      check("s2.asr.out", int'(r2_out), 'hEF);
      check("s2.asr.sout", int'(r2_sout), 3);
      r2_en = 0; r2_op = 3'b011; r2_start = 1; r2_count = 2;
      step();
      check("s2.seq.busy", int'(r2_busy), 1);
      r2_start = 0; r2_op = 3'b000;
      step();
      step();
      check("s2.seq.out", int'(r2_out), 'hFE);
      check("s2.seq.done", int'(r2_done), 1);

      // Random run against the reference model; dut state here is A5, idle
      m_out = 'hA5; m_rem = 0; m_lop = 0; m_busy = 0; m_done = 0;
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 60) == 0);
         load  = ($urandom_range(0, 11) == 0);
         start = ($urandom_range(0, 4) == 0);
         en    = 1'($urandom_range(0, 1));
         op    = 3'($urandom_range(0, 7));
         sin   = 1'($urandom_range(0, 1));
         count = 4'($urandom_range(0, 6));
         load_data = 8'($urandom);
         if (rst) begin
            m_out = 0; m_busy = 0; m_rem = 0; m_done = 0;
         end else begin
            m_done = 0;
            if (load) begin
               m_out = int'(load_data); m_busy = 0;
            end else if (m_busy) begin
               m_out = ref_shift(m_lop, m_out, int'(sin), 8, 1);
               m_rem = m_rem - 1;
               if (m_rem == 0) begin m_busy = 0; m_done = 1; end
            end else if (start) begin
               if (count != 0) begin m_busy = 1; m_rem = int'(count); m_lop = int'(op); end
               else m_done = 1;
            end else if (en) begin
               m_out = ref_shift(int'(op), m_out, int'(sin), 8, 1);
            end
         end
         step();
         check($sformatf("rnd%0d.out", c), int'(out), m_out);
         check($sformatf("rnd%0d.busy", c), int'(busy), int'(m_busy));
         check($sformatf("rnd%0d.done", c), int'(done), int'(m_done));
         check($sformatf("rnd%0d.sout", c), int'(sout),
               ref_sout(m_busy ? m_lop : int'(op), m_out, 8, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
